// File: rtl/vga_plot_arbiter.sv
// Sole driver of the vga_adapter write port: round-robin burst arbitration between pixel
// requesters, plus a background-copy engine that sweeps a full-screen ROM image.
module vga_plot_arbiter #(
    parameter int NREQ  = 3,
    parameter int XW    = 9,
    parameter int YW    = 8,
    parameter int CW    = 12,
    parameter int SCR_W = 320,
    parameter int SCR_H = 240,
    parameter int AW    = 17
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      last,
    input  logic [NREQ*XW-1:0]   req_x,
    input  logic [NREQ*YW-1:0]   req_y,
    input  logic [NREQ*CW-1:0]   req_c,
    output logic [NREQ-1:0]      gnt,
    input  logic                 bg_start,
    input  logic                 bg_sel,
    output logic [AW-1:0]        rom_addr,
    input  logic [CW-1:0]        rom_q_b,
    input  logic [CW-1:0]        rom_q_t,
    output logic                 bg_busy,
    output logic                 bg_done,
    output logic [XW-1:0]        x,
    output logic [YW-1:0]        y,
    output logic [CW-1:0]        colour,
    output logic                 plot
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(SCR_W * SCR_H - 1);
    localparam logic [XW-1:0] LAST_X    = XW'(SCR_W - 1);

    typedef enum logic [1:0] {IDLE, BURST, BG_RUN, BG_FLUSH} state_t;

    state_t          state, state_next;
    logic [IW-1:0]   rr_ptr, owner, pick, cand;
    logic            pick_valid;
    logic            bg_pend, sel_q, flush_cnt;
    logic            bg_take, accept, accept_last;
    logic [XW-1:0]   bx;
    logic [YW-1:0]   by;
    logic [AW-1:0]   addr;
    logic            s1_valid, s1_last, s2_valid, s2_last, out_last;
    logic [XW-1:0]   s1_x, s2_x;
    logic [YW-1:0]   s1_y, s2_y;

    // First requester strictly after rr_ptr in cyclic order, so the last owner goes last.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NREQ);
            if (!pick_valid && req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // A start request is ignored while a copy is already running or draining.
    assign bg_take     = bg_start && (state != BG_RUN) && (state != BG_FLUSH);
    assign accept      = (state == BURST) && req[owner];
    assign accept_last = accept && last[owner];

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bg_pend || bg_start)
                    state_next = BG_RUN;
                else if (pick_valid)
                    state_next = BURST;
            end
            BURST:    if (accept_last) state_next = IDLE;
            BG_RUN:   if (addr == LAST_ADDR) state_next = BG_FLUSH;
            BG_FLUSH: if (flush_cnt) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rr_ptr    <= IW'(NREQ - 1);
            owner     <= '0;
            gnt       <= '0;
            bg_pend   <= 1'b0;
            sel_q     <= 1'b0;
            bg_busy   <= 1'b0;
            bg_done   <= 1'b0;
            flush_cnt <= 1'b0;
            bx        <= '0;
            by        <= '0;
            addr      <= '0;
            rom_addr  <= '0;
        end else begin
            state   <= state_next;
            bg_done <= out_last;
            if (bg_take)
                sel_q <= bg_sel;
            if (bg_take)
                bg_busy <= 1'b1;
            else if (out_last)
                bg_busy <= 1'b0;

            case (state)
                IDLE: begin
                    bg_pend   <= 1'b0;
                    flush_cnt <= 1'b0;
                    bx        <= '0;
                    by        <= '0;
                    addr      <= '0;
                    if (state_next == BURST) begin
                        owner <= pick;
                        gnt   <= NREQ'(1) << pick;
                    end
                end
                BURST: begin
                    if (bg_take)
                        bg_pend <= 1'b1;
                    if (accept_last) begin
                        rr_ptr <= owner;
                        gnt    <= '0;
                    end
                end
                BG_RUN: begin
                    // Running address counter keeps addr == by*SCR_W + bx without a multiplier.
                    rom_addr <= addr;
                    addr     <= addr + 1'b1;
                    if (bx == LAST_X) begin
                        bx <= '0;
                        by <= by + 1'b1;
                    end else begin
                        bx <= bx + 1'b1;
                    end
                end
                BG_FLUSH: flush_cnt <= 1'b1;
                default: ;
            endcase
        end
    end

    // Coordinates trail the issued address by the ROM latency plus the output register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
            out_last <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
        end else begin
            s1_valid <= (state == BG_RUN);
            s1_last  <= (state == BG_RUN) && (addr == LAST_ADDR);
            s1_x     <= bx;
            s1_y     <= by;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_x     <= s1_x;
            s2_y     <= s1_y;
            out_last <= s2_last;
            if (s2_valid) begin
                x      <= s2_x;
                y      <= s2_y;
                colour <= sel_q ? rom_q_b : rom_q_t;
                plot   <= 1'b1;
            end else if (accept) begin
                x      <= req_x[int'(owner)*XW +: XW];
                y      <= req_y[int'(owner)*YW +: YW];
                colour <= req_c[int'(owner)*CW +: CW];
                plot   <= 1'b1;
            end else begin
                plot   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: requester bursts, background sweeps, and reset mid-sweep.
module tb_vga_plot_arbiter;

    localparam int NREQ  = 3;
    localparam int XW    = 9;
    localparam int YW    = 8;
    localparam int CW    = 12;
    localparam int SCR_W = 320;
    localparam int SCR_H = 240;
    localparam int AW    = 17;
    localparam int NPIX  = SCR_W * SCR_H;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
    } pix_t;

    logic                clk = 1'b0;
    logic                resetn;
    logic [NREQ-1:0]     req, last, gnt;
    logic [NREQ*XW-1:0]  req_x;
    logic [NREQ*YW-1:0]  req_y;
    logic [NREQ*CW-1:0]  req_c;
    logic                bg_start, bg_sel, bg_busy, bg_done, plot;
    logic [AW-1:0]       rom_addr;
    logic [CW-1:0]       rom_q_b, rom_q_t, colour;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;

    vga_plot_arbiter #(
        .NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW), .SCR_W(SCR_W), .SCR_H(SCR_H), .AW(AW)
    ) dut (
        .clk(clk), .resetn(resetn), .req(req), .last(last), .req_x(req_x), .req_y(req_y),
        .req_c(req_c), .gnt(gnt), .bg_start(bg_start), .bg_sel(bg_sel), .rom_addr(rom_addr),
        .rom_q_b(rom_q_b), .rom_q_t(rom_q_t), .bg_busy(bg_busy), .bg_done(bg_done),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] romB(input logic [AW-1:0] a);
        return a[11:0] ^ {a[16:12], 7'h2B};
    endfunction

    function automatic logic [CW-1:0] romT(input logic [AW-1:0] a);
        return ~a[11:0] ^ {7'h15, a[16:12]};
    endfunction

    // Synchronous ROM models with one cycle of read latency.
    always @(posedge clk) begin
        rom_q_b <= romB(rom_addr);
        rom_q_t <= romT(rom_addr);
    end

    int   assertCount = 0;
    int   failCount   = 0;
    pix_t sb[$];
    int   grantLog[$];

    int            active[NREQ], blen[NREQ], pix[NREQ], holeAt[NREQ], holeLen[NREQ];
    int            holeLeft[NREQ], accCnt[NREQ];
    logic [XW-1:0] cx[NREQ];
    logic [YW-1:0] cy[NREQ];
    logic [CW-1:0] cc[NREQ];
    logic          bgDefer, bgDeferSel, prevAccAny, prevPlot, chkG0;
    logic [XW-1:0] prevX;
    logic [YW-1:0] prevY;
    logic [NREQ-1:0] prevGnt;
    int            plotCnt, doneCnt;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed,
                     expected, $time);
        end
    endtask

    task automatic pushBg(input logic sel);
        pix_t e;
        for (int a = 0; a < NPIX; a++) begin
            e.x = XW'(a % SCR_W);
            e.y = YW'(a / SCR_W);
            e.c = sel ? romB(AW'(a)) : romT(AW'(a));
            sb.push_back(e);
        end
    endtask

    task automatic newPixel(input int i);
        cx[i] = XW'($urandom);
        cy[i] = YW'($urandom);
        cc[i] = CW'($urandom);
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            req[i]              = (active[i] > 0) && (holeLeft[i] == 0);
            last[i]             = (pix[i] == blen[i] - 1);
            req_x[i*XW +: XW]   = cx[i];
            req_y[i*YW +: YW]   = cy[i];
            req_c[i*CW +: CW]   = cc[i];
        end
    endtask

    task automatic startReq(input int i, input int bursts, input int len,
                            input int hAt, input int hLen);
        active[i]   = bursts;
        blen[i]     = len;
        pix[i]      = 0;
        holeAt[i]   = hAt;
        holeLen[i]  = hLen;
        holeLeft[i] = 0;
        accCnt[i]   = 0;
        newPixel(i);
        applyStimulus();
    endtask

    task automatic clearModel();
        for (int i = 0; i < NREQ; i++) begin
            active[i] = 0; blen[i] = 1; pix[i] = 0; holeAt[i] = -1; holeLen[i] = 0;
            holeLeft[i] = 0; accCnt[i] = 0; cx[i] = '0; cy[i] = '0; cc[i] = '0;
        end
        sb.delete();
        bgDefer    = 1'b0;
        bgDeferSel = 1'b0;
        prevAccAny = 1'b0;
        applyStimulus();
    endtask

    // One clock: check outputs and record acceptances at the negedge, then drive after the posedge.
    task automatic tick();
        logic [NREQ-1:0] acc;
        pix_t e;
        @(negedge clk);
        if (plot) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_plot", {x, y, colour}, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("pixel", {x, y, colour}, e);
            end
            plotCnt++;
        end
        if (bg_done) begin
            doneCnt++;
            checkOutput("done_after_last_plot", {prevPlot, prevX, prevY},
                        {1'b1, XW'(SCR_W - 1), YW'(SCR_H - 1)});
            checkOutput("busy_low_at_done", bg_busy, 0);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (active[i] > 0 && !req[i]) begin
                checkOutput("gnt_held_in_gap", gnt[i], 1);
                checkOutput("plot_in_gap", plot, prevAccAny);
            end
        end
        if (chkG0)
            checkOutput("gnt0_during_bg", gnt[0] & bg_busy, 0);
        if (gnt != '0 && prevGnt == '0) begin
            for (int i = 0; i < NREQ; i++)
                if (gnt[i]) grantLog.push_back(i);
        end
        prevGnt  = gnt;
        prevPlot = plot;
        prevX    = x;
        prevY    = y;
        acc        = req & gnt;
        prevAccAny = |acc;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                sb.push_back('{x: cx[i], y: cy[i], c: cc[i]});
                accCnt[i]++;
                if (pix[i] == blen[i] - 1) begin
                    pix[i] = 0;
                    active[i]--;
                    if (bgDefer) begin
                        pushBg(bgDeferSel);
                        bgDefer = 1'b0;
                    end
                end else begin
                    pix[i]++;
                    if (pix[i] == holeAt[i]) holeLeft[i] = holeLen[i];
                end
                if (active[i] > 0) newPixel(i);
            end
        end
        @(posedge clk);
        #1;
        bg_start = 1'b0;
        applyStimulus();
        for (int i = 0; i < NREQ; i++)
            if (holeLeft[i] > 0) holeLeft[i]--;
    endtask

    initial begin
        int n;
        resetn   = 1'b0;
        bg_start = 1'b0;
        bg_sel   = 1'b0;
        req      = '0;
        last     = '0;
        req_x    = '0;
        req_y    = '0;
        req_c    = '0;
        chkG0    = 1'b0;
        prevGnt  = '0;
        prevPlot = 1'b0;
        prevX    = '0;
        prevY    = '0;
        plotCnt  = 0;
        doneCnt  = 0;
        clearModel();
        repeat (3) tick();
        checkOutput("reset_vga", {x, y, colour, plot}, 0);
        checkOutput("reset_gnt", gnt, 0);
        checkOutput("reset_rom_addr", rom_addr, 0);
        checkOutput("reset_bg", {bg_busy, bg_done}, 0);
        resetn = 1'b1;
        tick();

        // Two requesters, two 2-pixel bursts each: grants must alternate starting at 0.
        grantLog.delete();
        startReq(0, 2, 2, -1, 0);
        startReq(1, 2, 2, -1, 0);
        n = 0;
        while (!(active[0] == 0 && active[1] == 0 && sb.size() == 0) && n < 200) begin
            tick(); n++;
        end
        checkOutput("rr_complete", (active[0] == 0 && active[1] == 0 && sb.size() == 0), 1);
        checkOutput("rr_grant_count", grantLog.size(), 4);
        for (int k = 0; k < grantLog.size() && k < 4; k++)
            checkOutput("rr_grant_order", grantLog[k], k % 2);
        repeat (2) tick();

        // Requester 1 drops req for three cycles mid-burst.
        startReq(1, 1, 5, 2, 3);
        n = 0;
        while (!(active[1] == 0 && sb.size() == 0) && n < 100) begin
            tick(); n++;
        end
        checkOutput("gap_burst_complete", accCnt[1], 5);
        checkOutput("gap_sb_empty", sb.size(), 0);
        repeat (2) tick();

        // Background copy requested mid-burst of requester 2 while requester 0 waits.
        plotCnt = 0;
        doneCnt = 0;
        startReq(2, 1, 4, -1, 0);
        n = 0;
        while (accCnt[2] < 2 && n < 50) begin
            tick(); n++;
        end
        checkOutput("bg_mid_burst_setup", accCnt[2], 2);
        bg_start = 1'b1;
        bg_sel   = 1'b1;
        if (pix[2] > 0) begin
            bgDefer    = 1'b1;
            bgDeferSel = 1'b1;
        end else begin
            pushBg(1'b1);
        end
        startReq(0, 1, 1, -1, 0);
        tick();
        chkG0 = 1'b1;
        n = 0;
        while (!(doneCnt >= 1 && active[0] == 0 && active[2] == 0 && sb.size() == 0)
               && n < NPIX + 200) begin
            tick(); n++;
        end
        chkG0 = 1'b0;
        repeat (3) tick();
        checkOutput("bg_sweep_complete", (active[0] == 0 && sb.size() == 0), 1);
        checkOutput("bg_total_plots", plotCnt, NPIX + 5);
        checkOutput("bg_done_once", doneCnt, 1);
        checkOutput("bg_busy_after", bg_busy, 0);

        // Title sweep interrupted by reset at pixel 1000, then a fresh board sweep.
        plotCnt  = 0;
        bg_start = 1'b1;
        bg_sel   = 1'b0;
        pushBg(1'b0);
        tick();
        n = 0;
        while (plotCnt < 1000 && n < 2000) begin
            tick(); n++;
        end
        checkOutput("title_plots_before_reset", plotCnt, 1000);
        resetn = 1'b0;
        #1;
        checkOutput("midreset_vga", {x, y, colour, plot}, 0);
        checkOutput("midreset_ctrl", {gnt, rom_addr, bg_busy, bg_done}, 0);
        clearModel();
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        checkOutput("post_reset_idle", {gnt, bg_busy, bg_done, plot}, 0);
        plotCnt  = 0;
        bg_start = 1'b1;
        bg_sel   = 1'b1;
        pushBg(1'b1);
        tick();
        n = 0;
        while (plotCnt < 400 && n < 1000) begin
            tick(); n++;
        end
        checkOutput("restart_plots", plotCnt, 400);
        checkOutput("restart_busy", bg_busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
